inst_loader: RTL and testbench
==============================

# inst_loader

Serial instruction loader inside `Chip`. It deserializes the `wInst` bit stream, clocked by `sclk` and gated by `IWEN`, into 32-bit words. Each completed word is written to the instruction memory at consecutive word addresses. While loading it holds the core in reset, so execution starts from address 0 once `IWEN` drops.

## Interface
- `ADDR_W`, 8: instruction memory word-address width; depth = 2**ADDR_W words.
- `SYNC_STAGES`, 2: synchronizer depth applied to `sclk`, `wInst` and `IWEN`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `IWEN`  in  1  load-session enable, asynchronous to `clk`.
- `sclk`  in  1  serial bit clock, asynchronous to `clk`; data is sampled on its rising edge.
- `wInst`  in  1  serial data, LSB of each word first.
- `imem_we`  out  1  one-`clk` write strobe.
- `imem_addr`  out  ADDR_W  word address of `imem_wdata`.
- `imem_wdata`  out  32  assembled instruction.
- `core_hold`  out  1  high while a session is active; the core must stay in reset.
- `word_count`  out  ADDR_W+1  words written in the current or last session.
- `ovf_err`  out  1  sticky flag: a word arrived after memory was full.

## Operation
- All three async inputs pass through `SYNC_STAGES` flops, each with the same depth, so data and strobe stay aligned.
- `sclk_rise` = synchronized `sclk` high and its previous value low.
- FSM states: IDLE, RECV, FULL. Reset state is IDLE.
- IDLE:
  - On synchronized `IWEN` = 1, go to RECV.
  - Clear `bit_cnt`, `imem_addr`, `word_count` and `ovf_err`.
- RECV, on each `sclk_rise`:
  - Shift right: `shreg <= {wInst_s, shreg[31:1]}`.
  - `bit_cnt` increments 0..31.
- RECV, on the 32nd bit:
  - Next cycle: `imem_wdata` = assembled word and `imem_we` = 1 for exactly one cycle at the current `imem_addr`.
  - In the cycle after the strobe, `imem_addr` and `word_count` increment.
  - `bit_cnt` wraps to 0.
- RECV, after a write at address 2**ADDR_W-1: go to FULL. `imem_addr` stays at the maximum and does not wrap.
- FULL:
  - Bits are still shifted in, but a completed word sets `ovf_err` and produces no `imem_we`.
- RECV or FULL, on synchronized `IWEN` = 0: go to IDLE.
  - A partial word (`bit_cnt` ≠ 0) is discarded.
  - `word_count` and `ovf_err` hold their values until the next session starts.
- `core_hold` = (state ≠ IDLE), registered.
- `sclk_rise` on the same cycle that `IWEN` falls: `IWEN` wins; the bit is dropped.
- `sclk_rise` on the same cycle that `IWEN` rises: the bit is dropped; shifting starts at the next edge.

## Timing
- Reset values: `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0, `core_hold` = 0, `word_count` = 0, `ovf_err` = 0, state = IDLE, shift register = 0.
- Asserting `rst` mid-word aborts the word immediately; no write is issued.
- Latency: `sclk` rise at the pin to bit shifted is `SYNC_STAGES`+1 `clk` edges.
- Latency: 32nd bit shifted to `imem_we` high is 1 `clk`.
- `sclk` high and low phases: each at least 1 `clk` period in simulation; at least `SYNC_STAGES` periods are required in silicon.
- `wInst` must be stable from 1 `clk` before to 1 `clk` after the `sclk` rising edge.
- Bench rate: `clk` 10 ns, `sclk` 20 ns period. A word takes 32 `sclk` periods (640 ns).
- `imem_wdata` and `imem_addr` are stable in the `imem_we` cycle. Memory writes on the `clk` rising edge that ends that cycle.

## Structure
- Shared package `chip_pkg`:
  - `INST_W` = 32.
  - state enum `loader_state_t` {IDLE, RECV, FULL}.
  - default `ADDR_W`.
- Sub-module `sync_bus #(WIDTH, STAGES)`: a bank of N-flop synchronizers, instantiated once for {`IWEN`, `sclk`, `wInst`}.
- The FSM, shift register and counters live in `inst_loader`.

## Test plan
- Single word: `IWEN` high, send 0x1304500a LSB first → one `imem_we` with addr 0, data 0x1304500a; `word_count` = 1.
- Program stream: nine words 0x1304500a, 0xa32e8006, 0x1305f00e, 0xa32fa006, 0x9304000f, 0x232f9006, 0x232e0006, 0x0326c007, 0x33068600, then `IWEN` low.
  - Expect writes at addr 0..8 in order and `word_count` = 9.
  - `core_hold` high throughout, then low 3 `clk` after `IWEN` falls.
- Aborted word: `IWEN` drops after 10 bits → no `imem_we`. A new session then loads 0xdeadbeef to addr 0.
- Reset mid-word: `rst` low after 20 bits of 0xa32e8006 → all outputs 0 immediately, no write. A following session writes at addr 0.
- Overflow with `ADDR_W` = 2:
  - Send 5 words → writes at addr 0..3, state FULL, 5th word gives no write and `ovf_err` = 1.
  - A new session clears `ovf_err`.
- Edge collision: `sclk` rise on the same synchronized cycle as `IWEN` rises → that bit is ignored. The next 32 bits form the word.

Source files
------------

// File: rtl/chip_pkg.sv
// Shared definitions for the serial instruction loader and its neighbours.
package chip_pkg;
    localparam int INST_W         = 32;
    localparam int ADDR_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } loader_state_t;
endpackage

// File: rtl/inst_loader_if.sv
// Serial load port plus instruction-memory write port of the loader.
// Handshake: imem_we is a one-cycle strobe. imem_addr/imem_wdata are valid
// only while imem_we is high, and the memory always accepts (no ready).
interface inst_loader_if #(
    parameter int ADDR_W = chip_pkg::ADDR_W_DEFAULT
);
    logic                        IWEN;
    logic                        sclk;
    logic                        wInst;
    logic                        imem_we;
    logic [ADDR_W-1:0]           imem_addr;
    logic [chip_pkg::INST_W-1:0] imem_wdata;
    logic                        core_hold;
    logic [ADDR_W:0]             word_count;
    logic                        ovf_err;
    logic [1:0]                  loader_state;

    modport master (
        output IWEN, sclk, wInst,
        input  imem_we, imem_addr, imem_wdata, core_hold, word_count,
               ovf_err, loader_state
    );

    modport slave (
        input  IWEN, sclk, wInst,
        output imem_we, imem_addr, imem_wdata, core_hold, word_count,
               ovf_err, loader_state
    );
endinterface

// File: rtl/sync_bus.sv
// Bank of equal-depth flop synchronizers so bits that change together
// leave the bank on the same cycle.
module sync_bus #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage [STAGES];

    // Shift the asynchronous inputs through STAGES flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];
endmodule

// File: rtl/inst_loader.sv
// Serial instruction loader: deserializes wInst (LSB first, sampled on sclk
// rise) into 32-bit words and writes them to consecutive memory addresses,
// holding the core in reset for the whole session.
module inst_loader
    import chip_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input logic         clk,
    input logic         rst,
    inst_loader_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_RECV = 2'(RECV);
    localparam logic [1:0] S_FULL = 2'(FULL);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [2:0]        sync_out;
    logic              iwen_s;
    logic              sclk_s;
    logic              winst_s;
    logic              sclk_prev;
    logic              sclk_rise;
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [INST_W-1:0] shreg;
    logic [4:0]        bit_cnt;
    logic              word_done;

    sync_bus #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({bus.IWEN, bus.sclk, bus.wInst}),
        .q   (sync_out)
    );

    assign {iwen_s, sclk_s, winst_s} = sync_out;
    assign sclk_rise        = sclk_s & ~sclk_prev;
    assign bus.loader_state = state;

    // Session FSM: IWEN has priority over any coincident sclk edge.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (iwen_s) state_next = S_RECV;
            S_RECV: begin
                if (!iwen_s)
                    state_next = S_IDLE;
                else if (bus.imem_we && bus.imem_addr == ADDR_MAX)
                    state_next = S_FULL;
            end
            S_FULL: if (!iwen_s) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Shift register, write pipeline, counters and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            sclk_prev      <= 1'b0;
            shreg          <= '0;
            bit_cnt        <= '0;
            word_done      <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            bus.core_hold  <= 1'b0;
            bus.word_count <= '0;
            bus.ovf_err    <= 1'b0;
        end else begin
            state         <= state_next;
            bus.core_hold <= (state_next != S_IDLE);
            sclk_prev     <= sclk_s;
            word_done     <= 1'b0;
            bus.imem_we   <= 1'b0;

            // A completed word is presented one cycle after its last bit.
            if (word_done) begin
                bus.imem_we    <= 1'b1;
                bus.imem_wdata <= shreg;
            end

            // Advance the address after the strobe; it saturates at the top.
            if (bus.imem_we) begin
                bus.word_count <= bus.word_count + (ADDR_W+1)'(1);
                if (bus.imem_addr != ADDR_MAX)
                    bus.imem_addr <= bus.imem_addr + ADDR_W'(1);
            end

            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    if (iwen_s) begin
                        bus.imem_addr  <= '0;
                        bus.word_count <= '0;
                        bus.ovf_err    <= 1'b0;
                    end
                end
                S_RECV, S_FULL: begin
                    if (!iwen_s) begin
                        bit_cnt <= '0;
                    end else if (sclk_rise) begin
                        shreg   <= {winst_s, shreg[INST_W-1:1]};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) begin
                            if (state == S_RECV) word_done   <= 1'b1;
                            else                 bus.ovf_err <= 1'b1;
                        end
                    end
                end
                default: bit_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: a full-size (ADDR_W=8) and a tiny (ADDR_W=2) loader
// share one serial stream; expected memory writes are queued per instance.
module tb_inst_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic iwen = 1'b0;
    logic sclk = 1'b0;
    logic winst = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int sess_words = 0;

    logic [39:0] exp_big_q[$];
    logic [33:0] exp_small_q[$];

    inst_loader_if #(.ADDR_W(8)) bus_big ();
    inst_loader_if #(.ADDR_W(2)) bus_small ();

    assign bus_big.IWEN    = iwen;
    assign bus_big.sclk    = sclk;
    assign bus_big.wInst   = winst;
    assign bus_small.IWEN  = iwen;
    assign bus_small.sclk  = sclk;
    assign bus_small.wInst = winst;

    inst_loader #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_big)
    );

    inst_loader #(.ADDR_W(2), .SYNC_STAGES(2)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_small)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: every write strobe must match the head of its queue
    always @(negedge clk) begin
        logic [39:0] eb;
        logic [33:0] es;
        if (bus_big.imem_we === 1'b1) begin
            n_vec++;
            if (exp_big_q.size() == 0) begin
                n_err++;
                $display("FAIL big_write: unexpected write addr=%0h data=%h, required none",
                         bus_big.imem_addr, bus_big.imem_wdata);
            end else begin
                eb = exp_big_q.pop_front();
                if ({bus_big.imem_addr, bus_big.imem_wdata} !== eb) begin
                    n_err++;
                    $display("FAIL big_write: got addr=%0h data=%h, required addr=%0h data=%h",
                             bus_big.imem_addr, bus_big.imem_wdata, eb[39:32], eb[31:0]);
                end
            end
        end
        if (bus_small.imem_we === 1'b1) begin
            n_vec++;
            if (exp_small_q.size() == 0) begin
                n_err++;
                $display("FAIL small_write: unexpected write addr=%0h data=%h, required none",
                         bus_small.imem_addr, bus_small.imem_wdata);
            end else begin
                es = exp_small_q.pop_front();
                if ({bus_small.imem_addr, bus_small.imem_wdata} !== es) begin
                    n_err++;
                    $display("FAIL small_write: got addr=%0h data=%h, required addr=%0h data=%h",
                             bus_small.imem_addr, bus_small.imem_wdata, es[33:32], es[31:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic send_bit(input logic b);
        @(negedge clk);
        winst = b;
        sclk  = 1'b0;
        @(negedge clk);
        sclk  = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[i]);
        if (nbits == 32) begin
            if (sess_words < 256) exp_big_q.push_back({8'(sess_words), w});
            if (sess_words < 4)   exp_small_q.push_back({2'(sess_words), w});
            sess_words++;
        end
    endtask

    task automatic start_session();
        @(negedge clk);
        sclk = 1'b0;
        iwen = 1'b1;
        sess_words = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic stop_session();
        repeat (6) @(negedge clk);
        iwen = 1'b0;
        sclk = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // scenarios
    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (bus_big.imem_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b required 0", bus_big.imem_we); end
        n_vec++; if (bus_big.imem_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr: got %0h required 0", bus_big.imem_addr); end
        n_vec++; if (bus_big.imem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h required 0", bus_big.imem_wdata); end
        n_vec++; if (bus_big.core_hold !== 1'b0) begin n_err++; $display("FAIL rst_hold: got %b required 0", bus_big.core_hold); end
        n_vec++; if (bus_big.word_count !== 9'd0) begin n_err++; $display("FAIL rst_wc: got %0d required 0", bus_big.word_count); end
        n_vec++; if (bus_big.ovf_err !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b required 0", bus_big.ovf_err); end
        n_vec++; if (bus_big.loader_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d required 0", bus_big.loader_state); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        start_session();
        send_word(32'h1304500a, 32);
        repeat (6) @(negedge clk);
        n_vec++; if (bus_big.word_count !== 9'd1) begin n_err++; $display("FAIL single_wc: got %0d required 1", bus_big.word_count); end
        n_vec++; if (bus_big.core_hold !== 1'b1) begin n_err++; $display("FAIL single_hold: got %b required 1", bus_big.core_hold); end
        n_vec++; if (exp_big_q.size() != 0) begin n_err++; $display("FAIL single_pending: got %0d writes outstanding required 0", exp_big_q.size()); end
        stop_session();
    endtask

    task automatic test_program();
        logic [31:0] prog [9];
        prog = '{32'h1304500a, 32'ha32e8006, 32'h1305f00e, 32'ha32fa006, 32'h9304000f,
                 32'h232f9006, 32'h232e0006, 32'h0326c007, 32'h33068600};
        start_session();
        foreach (prog[i]) send_word(prog[i], 32);
        repeat (6) @(negedge clk);
        n_vec++; if (bus_big.word_count !== 9'd9) begin n_err++; $display("FAIL prog_wc: got %0d required 9", bus_big.word_count); end
        n_vec++; if (bus_small.word_count !== 3'd4) begin n_err++; $display("FAIL prog_small_wc: got %0d required 4", bus_small.word_count); end
        n_vec++; if (bus_small.ovf_err !== 1'b1) begin n_err++; $display("FAIL prog_small_ovf: got %b required 1", bus_small.ovf_err); end
        n_vec++; if (bus_big.core_hold !== 1'b1) begin n_err++; $display("FAIL prog_hold: got %b required 1", bus_big.core_hold); end
        n_vec++; if (exp_big_q.size() != 0) begin n_err++; $display("FAIL prog_pending: got %0d writes outstanding required 0", exp_big_q.size()); end
        @(negedge clk);
        iwen = 1'b0;
        sclk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_vec++; if (bus_big.core_hold !== 1'b1) begin n_err++; $display("FAIL prog_hold_2clk: got %b required 1", bus_big.core_hold); end
        @(posedge clk);
        #1;
        n_vec++; if (bus_big.core_hold !== 1'b0) begin n_err++; $display("FAIL prog_hold_3clk: got %b required 0", bus_big.core_hold); end
        repeat (4) @(negedge clk);
        n_vec++; if (bus_big.word_count !== 9'd9) begin n_err++; $display("FAIL prog_wc_hold: got %0d required 9", bus_big.word_count); end
    endtask

    task automatic test_abort();
        start_session();
        send_word(32'hffffffff, 10);
        stop_session();
        n_vec++; if (bus_big.word_count !== 9'd0) begin n_err++; $display("FAIL abort_wc: got %0d required 0", bus_big.word_count); end
        n_vec++; if (bus_big.core_hold !== 1'b0) begin n_err++; $display("FAIL abort_hold: got %b required 0", bus_big.core_hold); end
        start_session();
        send_word(32'hdeadbeef, 32);
        stop_session();
        n_vec++; if (bus_big.word_count !== 9'd1) begin n_err++; $display("FAIL abort_next_wc: got %0d required 1", bus_big.word_count); end
        n_vec++; if (exp_big_q.size() != 0) begin n_err++; $display("FAIL abort_pending: got %0d writes outstanding required 0", exp_big_q.size()); end
    endtask

    task automatic test_reset_mid_word();
        start_session();
        send_word(32'ha32e8006, 20);
        #2;
        rst = 1'b0;
        #1;
        n_vec++; if (bus_big.imem_we !== 1'b0) begin n_err++; $display("FAIL midrst_we: got %b required 0", bus_big.imem_we); end
        n_vec++; if (bus_big.imem_addr !== 8'h00) begin n_err++; $display("FAIL midrst_addr: got %0h required 0", bus_big.imem_addr); end
        n_vec++; if (bus_big.imem_wdata !== 32'h0) begin n_err++; $display("FAIL midrst_wdata: got %h required 0", bus_big.imem_wdata); end
        n_vec++; if (bus_big.core_hold !== 1'b0) begin n_err++; $display("FAIL midrst_hold: got %b required 0", bus_big.core_hold); end
        n_vec++; if (bus_big.word_count !== 9'd0) begin n_err++; $display("FAIL midrst_wc: got %0d required 0", bus_big.word_count); end
        n_vec++; if (bus_small.ovf_err !== 1'b0) begin n_err++; $display("FAIL midrst_small_ovf: got %b required 0", bus_small.ovf_err); end
        iwen = 1'b0;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        start_session();
        send_word(32'h1305f00e, 32);
        stop_session();
        n_vec++; if (bus_big.word_count !== 9'd1) begin n_err++; $display("FAIL midrst_next_wc: got %0d required 1", bus_big.word_count); end
        n_vec++; if (exp_big_q.size() != 0) begin n_err++; $display("FAIL midrst_pending: got %0d writes outstanding required 0", exp_big_q.size()); end
    endtask

    task automatic test_overflow();
        start_session();
        for (int i = 0; i < 4; i++) send_word(32'($urandom()), 32);
        repeat (6) @(negedge clk);
        n_vec++; if (bus_small.loader_state !== 2'd2) begin n_err++; $display("FAIL ovf_state_full: got %0d required 2", bus_small.loader_state); end
        n_vec++; if (bus_small.ovf_err !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b required 0", bus_small.ovf_err); end
        n_vec++; if (bus_small.imem_addr !== 2'd3) begin n_err++; $display("FAIL ovf_addr_sat: got %0d required 3", bus_small.imem_addr); end
        send_word(32'($urandom()), 32);
        repeat (6) @(negedge clk);
        n_vec++; if (bus_small.ovf_err !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b required 1", bus_small.ovf_err); end
        n_vec++; if (bus_small.word_count !== 3'd4) begin n_err++; $display("FAIL ovf_small_wc: got %0d required 4", bus_small.word_count); end
        n_vec++; if (bus_big.word_count !== 9'd5) begin n_err++; $display("FAIL ovf_big_wc: got %0d required 5", bus_big.word_count); end
        n_vec++; if (exp_small_q.size() != 0) begin n_err++; $display("FAIL ovf_pending: got %0d writes outstanding required 0", exp_small_q.size()); end
        stop_session();
        n_vec++; if (bus_small.ovf_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b required 1", bus_small.ovf_err); end
        start_session();
        n_vec++; if (bus_small.ovf_err !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b required 0", bus_small.ovf_err); end
        n_vec++; if (bus_small.word_count !== 3'd0) begin n_err++; $display("FAIL ovf_wc_clear: got %0d required 0", bus_small.word_count); end
        n_vec++; if (bus_small.loader_state !== 2'd1) begin n_err++; $display("FAIL ovf_state_recv: got %0d required 1", bus_small.loader_state); end
        stop_session();
    endtask

    task automatic test_collision();
        @(negedge clk);
        sclk  = 1'b0;
        winst = 1'b1;
        @(negedge clk);
        iwen = 1'b1;
        sclk = 1'b1;
        sess_words = 0;
        send_word(32'h33068600, 32);
        stop_session();
        n_vec++; if (bus_big.word_count !== 9'd1) begin n_err++; $display("FAIL coll_wc: got %0d required 1", bus_big.word_count); end
        n_vec++; if (exp_big_q.size() != 0) begin n_err++; $display("FAIL coll_pending: got %0d writes outstanding required 0", exp_big_q.size()); end
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_single_word();
        test_program();
        test_abort();
        test_reset_mid_word();
        test_overflow();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
